ipsxb_distributed_fifo_wr_burst_v1_0: RTL and testbench
=======================================================

IPSXB_DISTRIBUTED_FIFO_WR_BURST_V1_0 -- requirements
Module: ipsxb_distributed_fifo_wr_burst_v1_0

Interface
REQ-001 Parameter DEPTH, default 9: FIFO address width; capacity CAP = 2^DEPTH words.
REQ-002 Parameter DATA_WIDTH, default 16: data word width.
REQ-003 Parameter LEN_WIDTH, default 10: burst length field width.
REQ-004 wr_clk  in  1  write-domain clock.
REQ-005 wrst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  burst request valid.
REQ-007 req_ready  out  1  burst request ready.
REQ-008 req_len  in  LEN_WIDTH  burst length in words.
REQ-009 s_valid  in  1  source data valid.
REQ-010 s_ready  out  1  source data ready.
REQ-011 s_data  in  DATA_WIDTH  source data.
REQ-012 fifo_w_en  out  1  FIFO write enable, registered.
REQ-013 fifo_wdata  out  DATA_WIDTH  FIFO write data, registered.
REQ-014 fifo_wfull  in  1  FIFO full flag.
REQ-015 fifo_wr_water_level  in  DEPTH+1  FIFO write-side fill level.
REQ-016 burst_done  out  1  one-cycle pulse with the last word's fifo_w_en.
REQ-017 len_err  out  1  one-cycle pulse on an illegal request.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_SPACE, XFER, SETTLE.
REQ-019 IDLE: req_ready=1; all other states: req_ready=0.
REQ-020 On req_valid&req_ready with 1 <= req_len <= CAP: latch len into remaining counter, go to WAIT_SPACE next cycle.
REQ-021 On req_valid&req_ready with req_len=0 or req_len>CAP: pulse len_err next cycle, stay IDLE, no writes.
REQ-022 WAIT_SPACE: free = CAP - fifo_wr_water_level, computed at DEPTH+2 bits; go to XFER when latched len <= free, else hold.
REQ-023 s_ready SHALL be 1 only in XFER with fifo_wfull=0.
REQ-024 Each s_valid&s_ready cycle: register s_data into fifo_wdata, assert fifo_w_en next cycle, decrement remaining.
REQ-025 fifo_w_en SHALL be 0 in every cycle not directly following an accepted word.
REQ-026 Accepting the word with remaining=1: go to SETTLE; burst_done asserts with that word's fifo_w_en.
REQ-027 SETTLE SHALL last exactly 2 cycles, then IDLE; covers level-update lag so the next space check is conservative.
REQ-028 Exactly len words SHALL be written per accepted burst, in source order, regardless of s_valid gaps or fifo_wfull stalls.
REQ-029 len=CAP at level 0 SHALL be accepted (exact fit boundary).
REQ-030 Level decreasing during WAIT_SPACE (reader draining) SHALL be acted on the cycle after it is observed.

Reset
REQ-031 On wrst: state=IDLE, remaining=0, fifo_w_en=0, fifo_wdata=0, burst_done=0, len_err=0, s_ready=0; req_ready=1 after release.
REQ-032 wrst mid-burst SHALL abandon the burst immediately; no partial-burst completion after release.

Structure
REQ-033 FSM state encoding and the SETTLE cycle count constant SHALL live in shared package ipsxb_distributed_fifo_pkg.
REQ-034 Single flat module; no sub-module.

Verification (DEPTH=4, CAP=16)
REQ-035 level=0, req len=8, s_valid held 1 -> IDLE,WAIT_SPACE,XFER; 8 fifo_w_en pulses in order, burst_done on 8th, req_ready=1 two cycles later.
REQ-036 level=12, len=8 -> held in WAIT_SPACE, s_ready=0; level driven to 8 -> XFER next cycle, 8 writes.
REQ-037 len=0 then len=17 -> len_err pulse each, zero fifo_w_en, req_ready stays 1.
REQ-038 len=16 at level 0, s_valid toggling, fifo_wfull forced 1 for 3 cycles mid-burst -> s_ready=0 those cycles, exactly 16 writes, data order preserved.
REQ-039 wrst after 3 of 8 words -> all outputs reset value same cycle; new len=4 burst writes exactly 4 words.

Source files
------------

// File: rtl/ipsxb_distributed_fifo_pkg.sv
// Shared definitions for the distributed FIFO write-burst logic:
// controller state encoding and the post-burst settle length.
package ipsxb_distributed_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    XFER       = 2'd2,
    SETTLE     = 2'd3
  } wr_burst_state_t;

  // Cycles spent after the last word so the FIFO water level catches up
  // before the next space check.
  localparam int SETTLE_CYCLES = 2;
  localparam int SETTLE_CNT_W  = 2;

endpackage

// File: rtl/ipsxb_distributed_fifo_wr_burst_v1_0.sv
// Burst write front-end: admits a length-tagged burst only once the FIFO has
// room for all of it, then streams exactly that many source words into the FIFO.
module ipsxb_distributed_fifo_wr_burst_v1_0
  import ipsxb_distributed_fifo_pkg::*;
#(
  parameter int DEPTH      = 9,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  wr_clk,
  input  logic                  wrst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  fifo_w_en,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_wfull,
  input  logic [DEPTH:0]        fifo_wr_water_level,
  output logic                  burst_done,
  output logic                  len_err
);

  // Handshakes: a transfer happens on a rising wr_clk edge when valid and
  // ready are both high; ready never depends on valid of the same channel.

  localparam logic [31:0]      CAP   = 32'd1 << DEPTH;
  localparam logic [DEPTH+1:0] CAP_W = {2'b01, {DEPTH{1'b0}}};

  wr_burst_state_t         state, state_nxt;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic [DEPTH+1:0]        free_words;
  logic [31:0]             req_len_ext;
  logic                    req_fire, len_ok, space_ok;
  logic                    accept, last_word, settle_end;

  assign req_ready   = (state == IDLE);
  assign s_ready     = (state == XFER) && !fifo_wfull;
  assign req_fire    = req_valid && req_ready;
  assign req_len_ext = 32'(req_len);
  assign len_ok      = (req_len_ext != 32'd0) && (req_len_ext <= CAP);
  assign free_words  = CAP_W - {1'b0, fifo_wr_water_level};
  assign space_ok    = 32'(remaining) <= 32'(free_words);
  assign accept      = s_valid && s_ready;
  assign last_word   = accept && (remaining == LEN_WIDTH'(1));
  assign settle_end  = (settle_cnt == SETTLE_CNT_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge wr_clk or posedge wrst) begin
    if (wrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (req_fire && len_ok) state_nxt = WAIT_SPACE;
      WAIT_SPACE: if (space_ok)           state_nxt = XFER;
      XFER:       if (last_word)          state_nxt = SETTLE;
      SETTLE:     if (settle_end)         state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wrst) begin
    if (wrst) begin
      remaining  <= '0;
      settle_cnt <= '0;
      fifo_w_en  <= 1'b0;
      fifo_wdata <= '0;
      burst_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      fifo_w_en  <= accept;
      burst_done <= last_word;
      len_err    <= req_fire && !len_ok;
      if (accept) fifo_wdata <= s_data;
      // remaining doubles as the latched length while waiting for space
      if (req_fire && len_ok) remaining <= req_len;
      else if (accept)        remaining <= remaining - 1'b1;
      if (state != SETTLE)    settle_cnt <= '0;
      else if (!settle_end)   settle_cnt <= settle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ipsxb_distributed_fifo_wr_burst_v1_0.sv
// Directed-plus-random bench for the burst write front-end (DEPTH=4, CAP=16).
module tb_ipsxb_distributed_fifo_wr_burst_v1_0;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int LW    = 10;
  localparam int CAP   = 16;

  // clock / reset
  logic wr_clk = 1'b0;
  logic wrst   = 1'b1;
  always #5 wr_clk = ~wr_clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [LW-1:0] req_len   = '0;
  logic          s_valid   = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data    = '0;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_wfull = 1'b0;
  logic [DEPTH:0] fifo_wr_water_level = '0;
  logic          burst_done;
  logic          len_err;

  ipsxb_distributed_fifo_wr_burst_v1_0 #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .wr_clk(wr_clk), .wrst(wrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fifo_w_en(fifo_w_en), .fifo_wdata(fifo_wdata), .fifo_wfull(fifo_wfull),
    .fifo_wr_water_level(fifo_wr_water_level),
    .burst_done(burst_done), .len_err(len_err)
  );

  // scoreboard: {last_of_burst, data} for every word the FIFO must receive
  int checks = 0;
  int errors = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] src_q[$];
  logic [DW:0]   mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge wr_clk) begin
    if (!wrst) begin
      if (fifo_w_en === 1'b1) begin
        chk("write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wdata", 32'(fifo_wdata), 32'(mon_e[DW-1:0]));
          chk("burst_done_last", {31'b0, burst_done}, {31'b0, mon_e[DW]});
        end
      end else begin
        chk("done_without_write", {31'b0, burst_done}, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic plan(input int len);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = DW'($urandom_range(0, 65535));
      src_q.push_back(d);
      exp_q.push_back({i == len - 1, d});
    end
  endtask

  task automatic send_req(input int len);
    req_len   = LW'(len);
    req_valid = 1'b1;
    @(negedge wr_clk);
    chk("req_ready_at_req", {31'b0, req_ready}, 32'd1);
    @(posedge wr_clk); #1;
    req_valid = 1'b0;
    req_len   = LW'($urandom_range(0, 1023));
  endtask

  // one cycle in WAIT_SPACE with enough room: no source acceptance yet
  task automatic wait_step();
    @(negedge wr_clk);
    chk("s_ready_wait", {31'b0, s_ready}, 32'd0);
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    @(posedge wr_clk); #1;
  endtask

  task automatic feed(input int gap_pct, input int stall_at, input int stall_len, input int max_hs);
    int it;
    int hs_cnt;
    bit hs;
    it = 0;
    hs_cnt = 0;
    while (src_q.size() > 0 && hs_cnt < max_hs && it < 400) begin
      s_valid    = ($urandom_range(0, 99) >= gap_pct);
      s_data     = s_valid ? src_q[0] : DW'($urandom_range(0, 65535));
      fifo_wfull = (it >= stall_at) && (it < stall_at + stall_len);
      @(negedge wr_clk);
      chk("s_ready_xfer", {31'b0, s_ready}, {31'b0, !fifo_wfull});
      hs = s_valid && s_ready;
      @(posedge wr_clk); #1;
      if (hs) begin
        void'(src_q.pop_front());
        hs_cnt++;
      end
      it++;
    end
    s_valid    = 1'b0;
    fifo_wfull = 1'b0;
    chk("feed_budget", {31'b0, it < 400}, 32'd1);
  endtask

  // called right after the last word was accepted
  task automatic finish_burst();
    @(negedge wr_clk);
    chk("burst_done_pulse", {31'b0, burst_done}, 32'd1);
    chk("req_ready_settle1", {31'b0, req_ready}, 32'd0);
    @(negedge wr_clk);
    chk("req_ready_settle2", {31'b0, req_ready}, 32'd0);
    @(negedge wr_clk);
    chk("req_ready_back", {31'b0, req_ready}, 32'd1);
    chk("all_words_written", 32'(exp_q.size()), 32'd0);
    @(posedge wr_clk); #1;
  endtask

  task automatic bad_req(input int len);
    send_req(len);
    @(negedge wr_clk);
    chk("len_err_pulse", {31'b0, len_err}, 32'd1);
    chk("req_ready_after_err", {31'b0, req_ready}, 32'd1);
    @(posedge wr_clk); #1;
    @(negedge wr_clk);
    chk("len_err_single", {31'b0, len_err}, 32'd0);
    @(posedge wr_clk); #1;
  endtask

  initial begin
    int lvl;
    int len;
    // reset state
    #1;
    chk("rst_fifo_w_en", {31'b0, fifo_w_en}, 32'd0);
    chk("rst_fifo_wdata", 32'(fifo_wdata), 32'd0);
    chk("rst_burst_done", {31'b0, burst_done}, 32'd0);
    chk("rst_len_err", {31'b0, len_err}, 32'd0);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    @(posedge wr_clk); @(posedge wr_clk); #1;
    wrst = 1'b0;
    @(negedge wr_clk);
    chk("req_ready_after_rst", {31'b0, req_ready}, 32'd1);
    @(posedge wr_clk); #1;

    // level 0, len 8, s_valid held high
    plan(8); send_req(8); wait_step();
    feed(0, 1000, 0, 1000);
    finish_burst();

    // level 12 leaves room for 4: an 8-word burst must wait
    fifo_wr_water_level = 5'd12;
    plan(8); send_req(8);
    for (int i = 0; i < 4; i++) begin
      @(negedge wr_clk);
      chk("s_ready_hold", {31'b0, s_ready}, 32'd0);
      chk("req_ready_hold", {31'b0, req_ready}, 32'd0);
      @(posedge wr_clk); #1;
    end
    fifo_wr_water_level = 5'd8;
    @(negedge wr_clk);
    chk("s_ready_level_seen", {31'b0, s_ready}, 32'd0);
    @(posedge wr_clk); #1;
    feed(0, 1000, 0, 1000);
    finish_burst();
    fifo_wr_water_level = '0;

    // illegal lengths
    bad_req(0);
    bad_req(CAP + 1);
    bad_req($urandom_range(CAP + 1, 1023));

    // exact-fit burst with source gaps and a 3-cycle full stall
    plan(CAP); send_req(CAP); wait_step();
    feed(40, 4, 3, 1000);
    finish_burst();

    // random bursts that fit the current level
    for (int r = 0; r < 4; r++) begin
      lvl = $urandom_range(0, 10);
      len = $urandom_range(1, CAP - lvl);
      fifo_wr_water_level = (DEPTH+1)'(lvl);
      plan(len); send_req(len); wait_step();
      feed($urandom_range(0, 50), $urandom_range(0, 6), $urandom_range(0, 3), 1000);
      finish_burst();
    end
    fifo_wr_water_level = '0;

    // reset after 3 of 8 words abandons the burst
    plan(8); send_req(8); wait_step();
    feed(20, 1000, 0, 3);
    wrst = 1'b1;
    #1;
    chk("midrst_fifo_w_en", {31'b0, fifo_w_en}, 32'd0);
    chk("midrst_fifo_wdata", 32'(fifo_wdata), 32'd0);
    chk("midrst_burst_done", {31'b0, burst_done}, 32'd0);
    chk("midrst_len_err", {31'b0, len_err}, 32'd0);
    chk("midrst_s_ready", {31'b0, s_ready}, 32'd0);
    exp_q.delete();
    src_q.delete();
    @(posedge wr_clk); #1;
    wrst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge wr_clk);
      chk("post_rst_idle", {31'b0, req_ready}, 32'd1);
      @(posedge wr_clk); #1;
    end
    plan(4); send_req(4); wait_step();
    feed(30, 1000, 0, 1000);
    finish_burst();

    repeat (3) @(posedge wr_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
